// File: rtl/leg_g_drv_pkg.sv
// Shared constants and helpers for the green-LED effect driver.
package leg_g_drv_pkg;

    localparam int LED_W = 9;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_DIM   = 2'd2,
        MODE_CHASE = 2'd3
    } mode_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_BRIGHT = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [7:0]  BRIGHT_RST = 8'hFF;
    localparam logic [15:0] PERIOD_RST = 16'd250;
    localparam logic [3:0]  CHASE_LAST = 4'd8;

    // Rotate left within LED_W bits: shift a doubled copy and keep the top half.
    function automatic logic [LED_W-1:0] rotl_led(input logic [LED_W-1:0] p,
                                                  input logic [3:0] k);
        logic [2*LED_W-1:0] d;
        d = {p, p} << k;
        return d[2*LED_W-1:LED_W];
    endfunction

endpackage

// File: rtl/leg_g_tick_gen.sv
// Base-tick prescaler and step timer for the LED effects.
module leg_g_tick_gen
    import leg_g_drv_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] period_i,
    input  logic        clear_i,
    output logic        tick_o,
    output logic        step_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   step_cnt_q, step_cnt_d;
    logic [15:0]   last_step;

    // Prescaler wraps freely; a clear only restarts the step count, and
    // a clear coinciding with a tick discards that tick's count.
    always_comb begin
        tick_o    = (pre_q == PRE_LAST);
        pre_d     = tick_o ? '0 : pre_q + PW'(1);
        last_step = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
        step_o    = tick_o && (step_cnt_q == last_step);
        step_cnt_d = step_cnt_q;
        if (clear_i) begin
            step_cnt_d = '0;
        end else if (step_o) begin
            step_cnt_d = '0;
        end else if (tick_o) begin
            step_cnt_d = step_cnt_q + 16'd1;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            step_cnt_q <= '0;
        end else begin
            pre_q      <= pre_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule

// File: rtl/leg_g_driver.sv
// Effect stage between the green-LED PIO and the leg_g pins, with its own
// zero-wait-state register slave for mode, brightness and step period.
module leg_g_driver
    import leg_g_drv_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] pattern_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] leg_g
);

    mode_e            mode_q, mode_d;
    logic             inv_q, inv_d;
    logic [7:0]       bright_q, bright_d;
    logic [15:0]      period_q, period_d;
    logic             blink_q, blink_d;
    logic [3:0]       chase_q, chase_d;
    logic [7:0]       pwm_q, pwm_d;
    logic [LED_W-1:0] leg_q, leg_d;
    logic [LED_W-1:0] effect;
    logic             wr, wr_ctrl, wr_bright, wr_period;
    logic             tick, step;
    logic             unused_bits;

    assign unused_bits = ^{writedata[31:16], tick};

    leg_g_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .period_i (period_q),
        .clear_i  (wr_ctrl | wr_period),
        .tick_o   (tick),
        .step_o   (step)
    );

    // Register writes, effect state, and the output mux; a CTRL write
    // overrides a step landing in the same cycle.
    always_comb begin
        wr        = chipselect && !write_n;
        wr_ctrl   = wr && (address == ADDR_CTRL);
        wr_bright = wr && (address == ADDR_BRIGHT);
        wr_period = wr && (address == ADDR_PERIOD);

        mode_d   = wr_ctrl   ? mode_e'(writedata[1:0]) : mode_q;
        inv_d    = wr_ctrl   ? writedata[2]            : inv_q;
        bright_d = wr_bright ? writedata[7:0]          : bright_q;
        period_d = wr_period ? writedata[15:0]         : period_q;

        blink_d = blink_q;
        chase_d = chase_q;
        if (wr_ctrl) begin
            blink_d = 1'b1;
            chase_d = 4'd0;
        end else if (step) begin
            blink_d = ~blink_q;
            chase_d = (chase_q == CHASE_LAST) ? 4'd0 : chase_q + 4'd1;
        end

        pwm_d = pwm_q + 8'd1;

        case (mode_q)
            MODE_PASS:  effect = pattern_in;
            MODE_BLINK: effect = blink_q ? pattern_in : '0;
            MODE_DIM:   effect = (pwm_q < bright_q) ? pattern_in : '0;
            MODE_CHASE: effect = rotl_led(pattern_in, chase_q);
            default:    effect = pattern_in;
        endcase
        leg_d = effect ^ {LED_W{inv_q}};
    end

    // Read mux follows address without chipselect gating.
    always_comb begin
        case (address)
            ADDR_CTRL:   readdata = {29'd0, inv_q, mode_q};
            ADDR_BRIGHT: readdata = {24'd0, bright_q};
            ADDR_PERIOD: readdata = {16'd0, period_q};
            ADDR_STATUS: readdata = {18'd0, blink_q, chase_q, leg_q};
            default:     readdata = 32'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_PASS;
            inv_q    <= 1'b0;
            bright_q <= BRIGHT_RST;
            period_q <= PERIOD_RST;
            blink_q  <= 1'b1;
            chase_q  <= 4'd0;
            pwm_q    <= 8'd0;
            leg_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            inv_q    <= inv_d;
            bright_q <= bright_d;
            period_q <= period_d;
            blink_q  <= blink_d;
            chase_q  <= chase_d;
            pwm_q    <= pwm_d;
            leg_q    <= leg_d;
        end
    end

    assign leg_g = leg_q;

endmodule

// File: tb/tb_leg_g_driver.sv
// Directed bench for leg_g_driver with a 4-cycle base tick.
module tb_leg_g_driver;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  pattern_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [8:0]  leg_g;

    int checks = 0;
    int errors = 0;

    logic [8:0]  legs [0:299];
    logic [31:0] sts  [0:299];

    leg_g_driver #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .pattern_in (pattern_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .leg_g      (leg_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nc(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic sample(input int n);
        address = 2'd3;
        #1;
        for (int i = 0; i < n; i++) begin
            legs[i] = leg_g;
            sts[i]  = readdata;
            cyc();
        end
    endtask

    task automatic count_on(input int n, output int on, output int bad);
        on  = 0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (leg_g !== 9'h000) on++;
            if (leg_g !== 9'h000 && leg_g !== 9'h1FF) bad++;
            cyc();
        end
    endtask

    initial begin
        int t [0:2];
        int nt, k, first, prev, bad, mism, pos, on;
        logic [3:0] cprev;
        bit found;
        int ch [0:2];
        int nch;

        reset = 1'b1; pattern_in = '0; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

        // 1. reset values and pass-through
        #12;
        check("reset_leg", 32'(leg_g), 32'h0);
        rd_check("reset_ctrl", 2'd0, 32'h0);
        rd_check("reset_bright", 2'd1, 32'hFF);
        rd_check("reset_period", 2'd2, 32'd250);
        rd_check("reset_status", 2'd3, 32'h2000);
        #3; reset = 1'b0;
        pattern_in = 9'h155;
        cyc();
        check("pass_155", 32'(leg_g), 32'h155);
        wr(2'd0, 32'd4);
        check("invert_latency", 32'(leg_g), 32'h155);
        cyc();
        check("invert_0aa", 32'(leg_g), 32'h0AA);

        // 2. blink with PERIOD=2
        pattern_in = 9'h1FF;
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd1);
        sample(40);
        t[0] = 0; t[1] = 0; t[2] = 0; nt = 0;
        for (int i = 2; i < 40; i++)
            if (legs[i] !== legs[i-1] && nt < 3) begin t[nt] = i; nt++; end
        check("blink_first_on", 32'(legs[1]), 32'h1FF);
        check("blink_first_step", {31'd0, (nt >= 1 && t[0] >= 6 && t[0] <= 9)}, 32'd1);
        check("blink_low_len", (nt >= 2) ? 32'(t[1] - t[0]) : 32'hFFFF_FFFF, 32'd8);
        check("blink_high_len", (nt >= 3) ? 32'(t[2] - t[1]) : 32'hFFFF_FFFF, 32'd8);
        check("blink_low_val", 32'(legs[t[0]]), 32'h0);
        check("blink_high_val", 32'(legs[t[1]]), 32'h1FF);
        mism = 0;
        for (int i = 1; i < 39; i++)
            if (sts[i][13] !== (legs[i+1] == 9'h1FF)) mism++;
        check("blink_status_phase", 32'(mism), 32'd0);

        // 3. chase with PERIOD=1
        pattern_in = 9'h001;
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd3);
        sample(50);
        check("chase_start", 32'(legs[1]), 32'h001);
        k = 0; first = -1; prev = -1; bad = 0;
        for (int i = 2; i < 50; i++) begin
            if (legs[i] !== legs[i-1]) begin
                k++;
                if (first < 0) first = i;
                else if (i - prev != 4) bad++;
                prev = i;
                if (legs[i] !== 9'(9'h001 << (k % 9))) bad++;
            end
        end
        check("chase_first_step", {31'd0, (first >= 2 && first <= 5)}, 32'd1);
        check("chase_sequence", 32'(bad), 32'd0);
        check("chase_wrapped", {31'd0, (k >= 10)}, 32'd1);
        mism = 0;
        for (int i = 1; i < 49; i++) begin
            pos = -1;
            for (int b = 0; b < 9; b++)
                if (legs[i+1] == (9'h001 << b)) pos = b;
            if (int'(sts[i][12:9]) != pos) mism++;
        end
        check("chase_status_pos", 32'(mism), 32'd0);

        // 4. PWM dimming
        pattern_in = 9'h1FF;
        wr(2'd1, 32'd64);
        wr(2'd0, 32'd2);
        cyc();
        count_on(256, on, bad);
        check("dim64_on", 32'(on), 32'd64);
        check("dim64_levels", 32'(bad), 32'd0);
        wr(2'd1, 32'd0);
        cyc();
        count_on(256, on, bad);
        check("dim0_on", 32'(on), 32'd0);
        wr(2'd1, 32'd255);
        cyc();
        count_on(256, on, bad);
        check("dim255_on", 32'(on), 32'd255);

        // 5. CTRL write landing on a step edge
        pattern_in = 9'h001;
        wr(2'd0, 32'd3);
        address = 2'd3;
        #1;
        cprev = readdata[12:9];
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (readdata[12:9] !== cprev) found = 1'b1;
            cprev = readdata[12:9];
        end
        check("collide_sync", {31'd0, found}, 32'd1);
        nc(3);
        wr(2'd0, 32'd3);
        rd_check("collide_pos_zero", 2'd3, {18'd0, 1'b1, 4'd0, leg_g});
        nc(3);
        check("collide_hold", 32'(readdata[12:9]), 32'd0);
        cyc();
        check("collide_next_step", 32'(readdata[12:9]), 32'd1);

        // PERIOD=0 steps on every tick
        wr(2'd2, 32'd0);
        rd_check("period0_read", 2'd2, 32'd0);
        address = 2'd3;
        #1;
        cprev = readdata[12:9];
        nch = 0; ch[0] = 0; ch[1] = 0; ch[2] = 0;
        for (int i = 0; i < 30 && nch < 3; i++) begin
            cyc();
            if (readdata[12:9] !== cprev) begin ch[nch] = i; nch++; end
            cprev = readdata[12:9];
        end
        check("period0_found", 32'(nch), 32'd3);
        check("period0_gap1", 32'(ch[1] - ch[0]), 32'd4);
        check("period0_gap2", 32'(ch[2] - ch[1]), 32'd4);

        // STATUS writes are ignored
        wr(2'd3, 32'hFFFF_FFFF);
        rd_check("status_wr_ctrl", 2'd0, 32'd3);
        rd_check("status_wr_period", 2'd2, 32'd0);

        // 6. reset in the middle of blink
        pattern_in = 9'h1FF;
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd1);
        nc(3);
        check("pre_reset_blink", 32'(leg_g), 32'h1FF);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_leg", 32'(leg_g), 32'h0);
        rd_check("async_reset_ctrl", 2'd0, 32'h0);
        rd_check("async_reset_period", 2'd2, 32'd250);
        rd_check("async_reset_status", 2'd3, 32'h2000);
        @(negedge clk);
        reset = 1'b0;
        pattern_in = 9'h0F0;
        #1;
        check("post_reset_hold", 32'(leg_g), 32'h0);
        cyc();
        check("post_reset_pass", 32'(leg_g), 32'h0F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
